// File: rtl/matrix_mult_engine_if.sv
// Configuration, operand-stream and result-stream handshake bundle for matrix_mult_engine.
interface matrix_mult_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 4,
  parameter int unsigned ACC_W  = 66
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIM_W-1:0]  R1;
  logic [DIM_W-1:0]  C1;
  logic [DIM_W-1:0]  R2;
  logic [DIM_W-1:0]  C2;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              cfg_err;

  modport master (
    output cfg_valid, R1, C1, R2, C2, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_last, busy, cfg_err
  );

  modport slave (
    input  cfg_valid, R1, C1, R2, C2, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_last, busy, cfg_err
  );
endinterface

// File: rtl/matrix_mult_engine.sv
// Runtime-sized sequential C = A x B, one MAC per cycle, valid/ready in and out.
// Define MATRIX_SIGNED_EN for two's-complement operands/results (default: unsigned).
module matrix_mult_engine #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_DIM = 4,
  parameter int unsigned DIM_W   = 4,
  parameter int unsigned ACC_W   = 2*DATA_W + $clog2(MAX_DIM)
) (
  input logic CLK,
  input logic RST,
  matrix_mult_engine_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(MAX_DIM);
  localparam int unsigned PROD_W = 2*DATA_W;
  localparam int unsigned EXT_W  = ACC_W - PROD_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_mem [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] b_mem [MAX_DIM][MAX_DIM];
  logic [IDX_W-1:0]  r1_m1, c1_m1, c2_m1;
  logic [IDX_W-1:0]  row_q, col_q, i_q, j_q, k_q;
  logic [ACC_W-1:0]  acc_q, acc_sum, out_data_q;
  logic              mac_done_q;
  logic              cfg_ready_q, in_ready_q, out_valid_q, out_last_q, busy_q, cfg_err_q;

  logic cfg_fire, cfg_ok, in_fire, out_fire, out_free;
  logic load_last_a, load_last_b, load_row_end, mac_en, res_load, final_elem;
  logic [IDX_W-1:0]  load_cols_m1;
  logic [DATA_W-1:0] a_el, b_el;
  logic [PROD_W-1:0] a_ext, b_ext, prod_full;
  logic [ACC_W-1:0]  prod_ext;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_err   = cfg_err_q;

  // Handshakes and loop-boundary decode
  assign cfg_fire     = bus.cfg_valid && cfg_ready_q;
  assign cfg_ok       = dim_ok(bus.R1) && dim_ok(bus.C1) && dim_ok(bus.R2) &&
                        dim_ok(bus.C2) && (bus.C1 == bus.R2);
  assign in_fire      = bus.in_valid && in_ready_q;
  assign out_fire     = out_valid_q && bus.out_ready;
  assign out_free     = !out_valid_q || bus.out_ready;
  assign load_cols_m1 = (state_q == S_LOAD_A) ? c1_m1 : c2_m1;
  assign load_row_end = (col_q == load_cols_m1);
  assign load_last_a  = in_fire && (state_q == S_LOAD_A) && (row_q == r1_m1) && (col_q == c1_m1);
  assign load_last_b  = in_fire && (state_q == S_LOAD_B) && (row_q == c1_m1) && (col_q == c2_m1);
  assign final_elem   = (i_q == r1_m1) && (j_q == c2_m1);
  // The closing MAC of an element only fires when the output register can take it
  assign mac_en       = (state_q == S_COMPUTE) && !mac_done_q && ((k_q != c1_m1) || out_free);
  assign res_load     = mac_en && (k_q == c1_m1);

  assign a_el = a_mem[i_q][k_q];
  assign b_el = b_mem[k_q][j_q];
`ifdef MATRIX_SIGNED_EN
  assign a_ext    = {{DATA_W{a_el[DATA_W-1]}}, a_el};
  assign b_ext    = {{DATA_W{b_el[DATA_W-1]}}, b_el};
  assign prod_ext = {{EXT_W{prod_full[PROD_W-1]}}, prod_full};
`else
  assign a_ext    = {{DATA_W{1'b0}}, a_el};
  assign b_ext    = {{DATA_W{1'b0}}, b_el};
  assign prod_ext = {{EXT_W{1'b0}}, prod_full};
`endif
  assign prod_full = a_ext * b_ext;
  assign acc_sum   = ((k_q == '0) ? '0 : acc_q) + prod_ext;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cfg_fire && cfg_ok)       state_d = S_LOAD_A;
      S_LOAD_A:  if (load_last_a)              state_d = S_LOAD_B;
      S_LOAD_B:  if (load_last_b)              state_d = S_COMPUTE;
      S_COMPUTE: if (out_fire && out_last_q)   state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Operand storage; contents are don't-care after reset
  always_ff @(posedge CLK) begin
    if (in_fire) begin
      if (state_q == S_LOAD_A) a_mem[row_q][col_q] <= bus.in_data;
      else                     b_mem[row_q][col_q] <= bus.in_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      r1_m1       <= '0;
      c1_m1       <= '0;
      c2_m1       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      mac_done_q  <= 1'b0;
    end else begin
      cfg_ready_q <= (state_d == S_IDLE);
      in_ready_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      busy_q      <= (state_d != S_IDLE);
      cfg_err_q   <= cfg_fire && !cfg_ok;

      if (cfg_fire && cfg_ok) begin
        r1_m1 <= IDX_W'(bus.R1 - DIM_W'(1));
        c1_m1 <= IDX_W'(bus.C1 - DIM_W'(1));
        c2_m1 <= IDX_W'(bus.C2 - DIM_W'(1));
        row_q <= '0;
        col_q <= '0;
      end

      if (load_last_a || load_last_b) begin
        row_q <= '0;
        col_q <= '0;
      end else if (in_fire) begin
        if (load_row_end) begin
          col_q <= '0;
          row_q <= row_q + IDX_W'(1);
        end else begin
          col_q <= col_q + IDX_W'(1);
        end
      end

      if (load_last_b) begin
        i_q        <= '0;
        j_q        <= '0;
        k_q        <= '0;
        mac_done_q <= 1'b0;
      end else if (mac_en) begin
        acc_q <= acc_sum;
        if (k_q == c1_m1) begin
          k_q <= '0;
          if (final_elem) begin
            mac_done_q <= 1'b1;
          end else if (j_q == c2_m1) begin
            j_q <= '0;
            i_q <= i_q + IDX_W'(1);
          end else begin
            j_q <= j_q + IDX_W'(1);
          end
        end else begin
          k_q <= k_q + IDX_W'(1);
        end
      end

      // Single output register: loads only when empty or being drained
      if (res_load) begin
        out_data_q  <= acc_sum;
        out_valid_q <= 1'b1;
        out_last_q  <= final_elem;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_mult_engine.sv
// Scoreboard bench for matrix_mult_engine: directed runs, expected C pushed at issue,
// monitor pops on every output handshake.
module tb_matrix_mult_engine;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_DIM = 4;
  localparam int unsigned DIM_W   = 4;
  localparam int unsigned ACC_W   = 2*DATA_W + $clog2(MAX_DIM);

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  matrix_mult_engine_if #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ACC_W(ACC_W)) bus ();

  matrix_mult_engine #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W), .ACC_W(ACC_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [DATA_W-1:0] a_q[$];
  logic [DATA_W-1:0] b_q[$];
  logic [ACC_W-1:0]  c_q[$];

  task automatic check(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected handshake (t=%0t)", name, $time);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_flags"},
          ACC_W'({bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.cfg_err}),
          ACC_W'(6'b100000));
    check({name, "_out_data"}, bus.out_data, '0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  always @(negedge CLK) begin
    if (!RST && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        timeout_fail("unexpected_output");
      end else begin
        mon_e = sb.pop_front();
        check("out_data", bus.out_data, mon_e.data);
        check("out_last", ACC_W'(bus.out_last), ACC_W'(mon_e.last));
      end
    end
  end

  task automatic do_cfg(input int r1, input int c1, input int r2, input int c2);
    bit done = 0;
    bus.R1 = DIM_W'(r1);
    bus.C1 = DIM_W'(c1);
    bus.R2 = DIM_W'(r2);
    bus.C2 = DIM_W'(c2);
    bus.cfg_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge CLK);
      if (bus.cfg_ready) done = 1;
      @(posedge CLK);
      #1;
    end
    bus.cfg_valid = 1'b0;
    if (!done) timeout_fail("cfg_handshake");
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge CLK);
      if (bus.in_ready) done = 1;
      @(posedge CLK);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) timeout_fail("in_handshake");
  endtask

  task automatic load_only(input int r1, input int c1, input int r2, input int c2);
    do_cfg(r1, c1, r2, c2);
    foreach (a_q[n]) send_beat(a_q[n]);
    foreach (b_q[n]) send_beat(b_q[n]);
  endtask

  task automatic start_run(input int r1, input int c1, input int r2, input int c2);
    foreach (c_q[n]) sb.push_back('{data: c_q[n], last: (n == c_q.size() - 1)});
    load_only(r1, c1, r2, c2);
  endtask

  task automatic finish_run(input string name);
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge CLK);
      if (bus.out_valid && bus.out_ready && bus.out_last) done = 1;
    end
    if (!done) begin
      timeout_fail({name, "_final"});
    end else begin
      @(posedge CLK);
      #1;
      check({name, "_busy_after"}, ACC_W'(bus.busy), '0);
      check({name, "_cfg_ready_after"}, ACC_W'(bus.cfg_ready), ACC_W'(1));
    end
  endtask

  task automatic load_test1;
    a_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_q = '{32'd5, 32'd6, 32'd7, 32'd8};
    c_q = '{ACC_W'(19), ACC_W'(22), ACC_W'(43), ACC_W'(50)};
  endtask

  task automatic pulse_reset(input string name);
    RST = 1'b1;
    #1;
    check_reset_outs(name);
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int lat;
    logic [DATA_W-1:0] big;
    bus.cfg_valid = 1'b0;
    bus.R1 = '0; bus.C1 = '0; bus.R2 = '0; bus.C2 = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs("reset");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // 2x2 * 2x2 with latency and in_ready drop checks
    load_test1();
    start_run(2, 2, 2, 2);
    check("in_ready_after_last_b", ACC_W'(bus.in_ready), '0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("first_latency", ACC_W'(lat), ACC_W'(2));
    finish_run("t1");

    // 2x3 * 3x1
    a_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    b_q = '{32'd1, 32'd1, 32'd1};
    c_q = '{ACC_W'(6), ACC_W'(15)};
    start_run(2, 3, 3, 1);
    finish_run("t2");

    // Rejected configurations
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       do_cfg(2, 3, 2, 2);
        1:       do_cfg(0, 2, 2, 2);
        default: do_cfg(2, 2, 2, MAX_DIM + 1);
      endcase
      check("cfg_err_pulse", ACC_W'(bus.cfg_err), ACC_W'(1));
      check("cfg_err_busy", ACC_W'(bus.busy), '0);
      check("cfg_err_in_ready", ACC_W'(bus.in_ready), '0);
      @(posedge CLK);
      #1;
      check("cfg_err_single", ACC_W'(bus.cfg_err), '0);
      check("cfg_err_idle", ACC_W'(bus.cfg_ready), ACC_W'(1));
    end

    // Back-pressure on the first result
    load_test1();
    bus.out_ready = 1'b0;
    start_run(2, 2, 2, 2);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    for (int n = 0; n < 5; n++) begin
      check("hold_valid", ACC_W'(bus.out_valid), ACC_W'(1));
      check("hold_data", bus.out_data, ACC_W'(19));
      @(posedge CLK);
      #1;
    end
    bus.out_ready = 1'b1;
    finish_run("t4");

    // Reset mid-LOAD_B and mid-COMPUTE, then a clean rerun
    load_test1();
    do_cfg(2, 2, 2, 2);
    foreach (a_q[n]) send_beat(a_q[n]);
    send_beat(b_q[0]);
    pulse_reset("rst_load_b");
    load_only(2, 2, 2, 2);
    @(posedge CLK);
    #1;
    pulse_reset("rst_compute");
    start_run(2, 2, 2, 2);
    finish_run("t5");

    // Outer product, C1=1 full-rate output
    a_q = '{32'd2, 32'd3};
    b_q = '{32'd4, 32'd5};
    c_q = '{ACC_W'(8), ACC_W'(10), ACC_W'(12), ACC_W'(15)};
    start_run(2, 1, 1, 2);
    finish_run("outer");

    // Signedness and extreme operands
`ifdef MATRIX_SIGNED_EN
    a_q = '{DATA_W'(-3)};
    b_q = '{32'd7};
    c_q = '{ACC_W'(-21)};
    start_run(1, 1, 1, 1);
    finish_run("sign_ext");
    big = 32'h8000_0000;
`else
    a_q = '{32'hFFFF_FFFF};
    b_q = '{32'd2};
    c_q = '{66'h1_FFFF_FFFE};
    start_run(1, 1, 1, 1);
    finish_run("zero_ext");
    big = 32'hFFFF_FFFF;
`endif
    a_q.delete();
    b_q.delete();
    c_q.delete();
    for (int n = 0; n < MAX_DIM*MAX_DIM; n++) begin
      a_q.push_back(big);
      b_q.push_back(big);
`ifdef MATRIX_SIGNED_EN
      c_q.push_back(66'h1_0000_0000_0000_0000);
`else
      c_q.push_back(66'h3_FFFF_FFF8_0000_0004);
`endif
    end
    start_run(MAX_DIM, MAX_DIM, MAX_DIM, MAX_DIM);
    finish_run("max_val");

    check("sb_drained", ACC_W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
